// File: rtl/sht30_pkg.sv
// Shared types and constants for the SHT30 raw-code to BCD converter.
package sht30_pkg;

  typedef enum logic [2:0] {
    IDLE, WAIT_STABLE, MUL, SIGN, BCD, DONE
  } state_t;

  localparam int          STABLE_CYCLES_DEF = 100000;
  localparam logic [10:0] T_SCALE  = 11'd1750;
  localparam logic [9:0]  H_SCALE  = 10'd1000;
  localparam logic [10:0] T_OFFSET = 11'd450;

  // One double-dabble step: add 3 to every digit >= 5, then shift in_bit in.
  function automatic logic [15:0] dd_step(input logic [15:0] b, input logic in_bit);
    logic [15:0] r;
    for (int i = 0; i < 4; i++)
      r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
    return 16'({r, in_bit});
  endfunction

endpackage

// File: rtl/bin2bcd12.sv
// Sequential 12-bit binary to 4-digit BCD (double-dabble), 12 shift cycles after start.
module bin2bcd12
  import sht30_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [11:0] bin,
  output logic        done,
  output logic [15:0] bcd
);

  logic [11:0] sh;
  logic [15:0] acc;
  logic [3:0]  cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh  <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (start) begin
      sh  <= bin;
      acc <= '0;
      cnt <= 4'd12;
    end else if (cnt != 4'd0) begin
      acc <= dd_step(acc, sh[11]);
      sh  <= {sh[10:0], 1'b0};
      cnt <= cnt - 4'd1;
    end
  end

  // High during the final shift cycle, so the result is ready on the next clock.
  assign done = (cnt == 4'd1);
  assign bcd  = acc;

endmodule

// File: rtl/sht30_data_conv.sv
// Debounces raw SHT30 temperature/humidity codes and converts them to signed BCD
// tenths of a degree C and BCD tenths of a percent RH.
module sht30_data_conv
  import sht30_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] t_code,
  input  logic [15:0] h_code,
  output logic        temp_neg,
  output logic [15:0] temp_bcd,
  output logic [15:0] hum_bcd,
  output logic        valid,
  output logic        busy
);

  localparam int CW = $clog2(STABLE_CYCLES);

  state_t       state, state_nx;
  logic [31:0]  in_pair, cand, snap;
  logic [CW-1:0] cnt, cnt_nx;
  logic [3:0]   mcnt;
  logic [15:0]  t_sh, h_sh;
  logic [10:0]  tp;
  logic [9:0]   hp;
  logic         neg_c, neg_r;
  logic [11:0]  mag;
  logic         bcd_start, t_done, h_done;
  logic [15:0]  t_bcd, h_bcd;

  assign in_pair = {t_code, h_code};
  assign cnt_nx  = cnt + 1'b1;

  // The candidate register counts as the first stable cycle, so the count that
  // would reach STABLE_CYCLES-1 is the one that launches the multiply.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:        if (in_pair != snap) state_nx = WAIT_STABLE;
      WAIT_STABLE: if (in_pair == cand && cnt_nx == CW'(STABLE_CYCLES - 1)) state_nx = MUL;
      MUL:         if (mcnt == 4'd15) state_nx = SIGN;
      SIGN:        state_nx = BCD;
      BCD:         if (t_done && h_done) state_nx = DONE;
      DONE:        state_nx = IDLE;
      default:     state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  assign busy      = (state != IDLE);
  assign bcd_start = (state == SIGN);
  assign neg_c     = (tp < T_OFFSET);
  assign mag       = neg_c ? 12'(T_OFFSET - tp) : 12'(tp - T_OFFSET);

  // Right-shifting shift-add: the low 16 product bits fall off one per cycle, so
  // after 16 steps tp/hp hold exactly product >> 16.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cand     <= '0;
      snap     <= '0;
      cnt      <= '0;
      mcnt     <= '0;
      t_sh     <= '0;
      h_sh     <= '0;
      tp       <= '0;
      hp       <= '0;
      neg_r    <= 1'b0;
      temp_neg <= 1'b0;
      temp_bcd <= '0;
      hum_bcd  <= '0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: if (in_pair != snap) begin
          cand <= in_pair;
          cnt  <= '0;
        end
        WAIT_STABLE: if (in_pair != cand) begin
          cand <= in_pair;
          cnt  <= '0;
        end else begin
          cnt <= cnt_nx;
          if (cnt_nx == CW'(STABLE_CYCLES - 1)) begin
            mcnt <= '0;
            tp   <= '0;
            hp   <= '0;
            t_sh <= cand[31:16];
            h_sh <= cand[15:0];
          end
        end
        MUL: begin
          tp   <= 11'(({1'b0, tp} + (t_sh[0] ? {1'b0, T_SCALE} : 12'd0)) >> 1);
          hp   <= 10'(({1'b0, hp} + (h_sh[0] ? {1'b0, H_SCALE} : 11'd0)) >> 1);
          t_sh <= t_sh >> 1;
          h_sh <= h_sh >> 1;
          mcnt <= mcnt + 4'd1;
        end
        SIGN: neg_r <= neg_c;
        DONE: begin
          temp_neg <= neg_r;
          temp_bcd <= t_bcd;
          hum_bcd  <= h_bcd;
          snap     <= cand;
          valid    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  bin2bcd12 u_t_bcd (
    .clk(clk), .rst_n(rst_n), .start(bcd_start), .bin(mag),
    .done(t_done), .bcd(t_bcd)
  );

  bin2bcd12 u_h_bcd (
    .clk(clk), .rst_n(rst_n), .start(bcd_start), .bin({2'b00, hp}),
    .done(h_done), .bcd(h_bcd)
  );

endmodule

// File: tb/tb_sht30_data_conv.sv
// Directed bench for sht30_data_conv with an arithmetic reference model and scoreboard.
module tb_sht30_data_conv;

  localparam int SC = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] t_code = '0, h_code = '0;
  logic        temp_neg, valid, busy;
  logic [15:0] temp_bcd, hum_bcd;

  always #5 clk = ~clk;

  sht30_data_conv #(.STABLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n), .t_code(t_code), .h_code(h_code),
    .temp_neg(temp_neg), .temp_bcd(temp_bcd), .hum_bcd(hum_bcd),
    .valid(valid), .busy(busy)
  );

  typedef struct packed {
    logic        neg;
    logic [15:0] tb;
    logic [15:0] hb;
  } res_t;

  int   cmp_n = 0, err_n = 0, vld_n = 0;
  res_t exp_q[$];
  res_t last = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_n++;
    if (act !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input longint v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Tenths of a degree / percent straight from the datasheet formulas, floored.
  function automatic res_t model(input logic [15:0] t, input logic [15:0] h);
    res_t   r;
    longint tt, hh, d;
    tt = (longint'(t) * 1750) / 65536;
    hh = (longint'(h) * 1000) / 65536;
    d  = tt - 450;
    r.neg = (d < 0);
    if (d < 0) d = -d;
    r.tb = to_bcd(d);
    r.hb = to_bcd(hh);
    return r;
  endfunction

  always @(negedge clk) begin
    res_t cur, e;
    cur = {temp_neg, temp_bcd, hum_bcd};
    if (!rst_n) begin
      check("reset_outputs", {valid, busy, cur}, 64'd0);
      last = '0;
    end else if (valid) begin
      vld_n++;
      if (exp_q.size() == 0) begin
        cmp_n++;
        err_n++;
        $display("FAIL unexpected_valid: got result %0h want no pulse", cur);
      end else begin
        e = exp_q.pop_front();
        check("result", cur, e);
      end
      last = cur;
    end else begin
      check("hold", cur, last);
    end
  end

  task automatic set_in(input logic [15:0] t, input logic [15:0] h);
    @(posedge clk);
    #1;
    t_code = t;
    h_code = h;
  endtask

  task automatic wait_valid(input int lim, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!valid && n < lim);
    if (!valid) begin
      cmp_n++;
      err_n++;
      $display("FAIL valid_timeout: got no pulse within %0d clocks want a pulse", lim);
    end
  endtask

  task automatic run_conv(input logic [15:0] t, input logic [15:0] h,
                          input res_t lit, input string nm);
    int   n, v0;
    res_t m;
    v0 = vld_n;
    set_in(t, h);
    exp_q.push_back(model(t, h));
    wait_valid(1100, n);
    check({nm, "_latency"}, n, 1030);
    check({nm, "_dut"}, {temp_neg, temp_bcd, hum_bcd}, lit);
    m = model(t, h);
    check({nm, "_model"}, m, lit);
    repeat (40) @(posedge clk);
    #1;
    check({nm, "_pulses"}, vld_n - v0, 1);
    check({nm, "_busy"}, busy, 0);
  endtask

  initial begin
    int n, v0;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("zero_pair_no_start", busy, 0);

    run_conv(16'h6666, 16'h6666, {1'b0, 16'h0249, 16'h0399}, "c6666");
    run_conv(16'h0000, 16'h0000, {1'b1, 16'h0450, 16'h0000}, "c0000");
    run_conv(16'hFFFF, 16'hFFFF, {1'b0, 16'h1299, 16'h0999}, "cFFFF");
    run_conv(16'h4000, 16'h4000, {1'b1, 16'h0013, 16'h0250}, "c4000");

    // Byte-torn temperature update: high byte first, low byte 500 clocks later.
    v0 = vld_n;
    set_in(16'h9A00, 16'h4000);
    repeat (500) @(posedge clk);
    #1 t_code = 16'h9ABC;
    exp_q.push_back(model(16'h9ABC, 16'h4000));
    wait_valid(1100, n);
    check("torn_latency", n, 1030);
    check("torn_value", {temp_neg, temp_bcd, hum_bcd}, {1'b0, 16'h0607, 16'h0250});
    repeat (40) @(posedge clk);
    #1 check("torn_pulses", vld_n - v0, 1);

    // Inputs change in MUL cycle 5: old pair finishes, new pair follows.
    set_in(16'h6666, 16'h1234);
    repeat (1005) @(posedge clk);
    #1 check("mul_busy", busy, 1);
    t_code = 16'h3000;
    h_code = 16'h8000;
    exp_q.push_back(model(16'h6666, 16'h1234));
    exp_q.push_back(model(16'h3000, 16'h8000));
    wait_valid(100, n);
    check("mul_first_latency", n, 25);
    check("mul_first_temp", {temp_neg, temp_bcd}, {1'b0, 16'h0249});
    wait_valid(1100, n);
    check("mul_second_latency", n, 1030);
    check("mul_second_value", {temp_neg, temp_bcd, hum_bcd}, {1'b1, 16'h0122, 16'h0500});

    // Reset pulse while in BCD aborts the conversion.
    set_in(16'h5000, 16'h7000);
    repeat (1020) @(posedge clk);
    #1 check("bcd_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check("abort_outputs", {valid, busy, temp_neg, temp_bcd, hum_bcd}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.push_back(model(16'h5000, 16'h7000));
    wait_valid(1100, n);
    check("reconv_latency", n, 1030);
    check("reconv_value", {temp_neg, temp_bcd, hum_bcd}, {1'b0, 16'h0096, 16'h0437});

    repeat (20) @(posedge clk);
    #1 check("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
